bus_xfer_ctrl: RTL and testbench
================================

Name: bus_xfer_ctrl

Overview:
Control-side counterpart of the shared multi-source bus mux. It accepts (source, destination) transfer requests over a valid/ready handshake and drives the one-hot source-enable vector into the bus mux. After a settle period it captures the mux output into one of DST_COUNT destination registers and pulses that register's load strobe. It sits between the sequencing logic (buttons/microcode) and the bus mux, and holds the bank of sink registers.

Parameters:
WIDTH, 8, bus data width in bits
SRC_COUNT, 4, number of bus sources (width of the enable vector)
DST_COUNT, 4, number of destination registers
SETTLE, 1, cycles the bus is driven before capture; must be >= 1, elaboration error otherwise

Ports:
clk_25mhz  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
req_valid  input  1  transfer request present
req_ready  output  1  high only in IDLE; request accepted on clk edge with req_valid && req_ready
req_src  input  SW=max(1,$clog2(SRC_COUNT))  source index
req_dst  input  DW=max(1,$clog2(DST_COUNT))  destination index
src_enable  output  SRC_COUNT  one-hot bus enable; bit i selects bus source i; all-zero when idle
bus_in  input  WIDTH  bus mux output
dst_load  output  DST_COUNT  one-cycle load strobe, bit d for destination d
dst_data  output  DST_COUNT*WIDTH  destination registers; register d at [d*WIDTH +: WIDTH]
busy  output  1  high in any state other than IDLE
done  output  1  one-cycle pulse at transfer completion
err  output  1  valid with done; high if req_src or req_dst was out of range

Behaviour:
- Reset (async assert): state=IDLE, src_enable=0, dst_load=0, dst_data=0, done=0, err=0, counter=0. Enables drop immediately, with no clock needed. Reset mid-transfer abandons it: no load, no done.
- All outputs are registered or decoded from state only. There is no combinational input-to-output path.
- States: IDLE, DRIVE, LOAD, DONE.
- IDLE: req_ready=1. On accept, latch src/dst.
  - If src >= SRC_COUNT or dst >= DST_COUNT: go to DONE with err_next=1. src_enable stays 0 and nothing is loaded.
  - Otherwise: src_enable <= onehot(src), counter <= SETTLE, go to DRIVE.
- DRIVE: src_enable held. counter decrements each cycle; when counter==1, go to LOAD. DRIVE lasts exactly SETTLE cycles.
- LOAD (one cycle): src_enable held, dst_load[dst]=1. At the closing edge, dst_data[dst] <= bus_in; then src_enable <= 0 and go to DONE.
- DONE (one cycle): done=1, err as latched, src_enable=0. Then go to IDLE; err clears on leaving DONE.
- Timing, with accept at edge E0 (cycles numbered after E0):
  - src_enable high cycles 1..SETTLE+1
  - dst_load high cycle SETTLE+1
  - new dst_data visible and done=1 cycle SETTLE+2
  - req_ready=1 again cycle SETTLE+3
  - Error path: done at cycle 1, ready at cycle 2.
- Throughput: one transfer per SETTLE+3 cycles. Requests are never queued; req_valid in non-IDLE states is ignored (ready=0). req_src/req_dst changes after accept have no effect.
- src_enable is never multi-hot. It is zero in IDLE and DONE, so sources never overlap across back-to-back transfers.
- Untargeted destination registers hold their value. Loading the same dst twice overwrites it.
- bus_in is sampled only at the LOAD closing edge. Its value in other cycles is don't-care.

Decomposition:
- Package bus_pkg:
  - state enum (IDLE, DRIVE, LOAD, DONE; 2-bit encoding)
  - index-width helper function
  - default WIDTH/SRC_COUNT/DST_COUNT constants shared with the bus mux
- Sub-module bus_sink_bank (WIDTH, DST_COUNT):
  - async-reset register bank
  - inputs: load index, load enable, data
  - outputs: packed dst_data and registered dst_load strobe
- The FSM, counter and enable decode stay in bus_xfer_ctrl.

Test Plan:
- Reset, then idle: src_enable=0, dst_data all 0, req_ready=1, busy=0, done=0.
- Bench bus mux with sources {8'h99,8'h55,8'haa,8'h66} at indices 0..3, SETTLE=1. Request src=2, dst=1 at E0: src_enable=4'b0100 cycles 1-2, dst_load=4'b0010 cycle 2, dst_data[15:8]=8'haa and done=1 cycle 3, err=0, ready cycle 4.
- Back-to-back requests src=0→dst=3 then src=3→dst=0 with req_valid held: second accepted at first ready; final dst_data=32'h99_00_00_66. src_enable is never multi-hot and is 0 for at least one cycle between transfers.
- SRC_COUNT=3 instance, request src=3: done+err at cycle 1, src_enable never nonzero, dst_load never asserted, dst_data unchanged.
- SETTLE=4, assert reset during DRIVE cycle 2: src_enable=0 immediately. No dst_load, no done, dst_data=0; ready right after reset release.
- Change bus_in to 8'h00 during DRIVE but 8'h5a during LOAD: captured value is 8'h5a.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared types and constants for the bus transfer controller and the bus mux it drives.
package bus_pkg;

    localparam int unsigned BUS_WIDTH     = 8;
    localparam int unsigned BUS_SRC_COUNT = 4;
    localparam int unsigned BUS_DST_COUNT = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        LOAD  = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Index width for n items, never narrower than one bit.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bus_xfer_ctrl_if.sv
// Request handshake plus bus/sink signals between the sequencer and the transfer controller.
interface bus_xfer_ctrl_if
    import bus_pkg::*;
#(
    parameter int unsigned WIDTH     = BUS_WIDTH,
    parameter int unsigned SRC_COUNT = BUS_SRC_COUNT,
    parameter int unsigned DST_COUNT = BUS_DST_COUNT
) ();

    localparam int unsigned SW = idx_w(SRC_COUNT);
    localparam int unsigned DW = idx_w(DST_COUNT);

    logic                       req_valid;
    logic                       req_ready;
    logic [SW-1:0]              req_src;
    logic [DW-1:0]              req_dst;
    logic [SRC_COUNT-1:0]       src_enable;
    logic [WIDTH-1:0]           bus_in;
    logic [DST_COUNT-1:0]       dst_load;
    logic [DST_COUNT*WIDTH-1:0] dst_data;
    logic                       busy;
    logic                       done;
    logic                       err;

    modport slave (
        input  req_valid, req_src, req_dst, bus_in,
        output req_ready, src_enable, dst_load, dst_data, busy, done, err
    );

    modport master (
        output req_valid, req_src, req_dst, bus_in,
        input  req_ready, src_enable, dst_load, dst_data, busy, done, err
    );

endinterface

// File: rtl/bus_sink_bank.sv
// Bank of destination registers; the registered load strobe also gates the capture of data.
module bus_sink_bank
    import bus_pkg::*;
#(
    parameter int unsigned WIDTH     = BUS_WIDTH,
    parameter int unsigned DST_COUNT = BUS_DST_COUNT
) (
    input  logic                       clk_25mhz,
    input  logic                       reset,
    input  logic [idx_w(DST_COUNT)-1:0] load_idx,
    input  logic                       load_en,
    input  logic [WIDTH-1:0]           data,
    output logic [DST_COUNT-1:0]       dst_load,
    output logic [DST_COUNT*WIDTH-1:0] dst_data
);

    // Strobe is raised for the LOAD cycle; data is taken at that cycle's closing edge.
    always_ff @(posedge clk_25mhz or posedge reset) begin
        if (reset) begin
            dst_load <= '0;
            dst_data <= '0;
        end else begin
            for (int d = 0; d < int'(DST_COUNT); d++) begin
                dst_load[d] <= load_en && (32'(load_idx) == 32'(d));
                if (dst_load[d]) begin
                    dst_data[d*WIDTH +: WIDTH] <= data;
                end
            end
        end
    end

endmodule

// File: rtl/bus_xfer_ctrl.sv
// Transfer sequencer: drives one-hot bus enables, waits SETTLE cycles, then loads a sink register.
module bus_xfer_ctrl
    import bus_pkg::*;
#(
    parameter int unsigned WIDTH     = BUS_WIDTH,
    parameter int unsigned SRC_COUNT = BUS_SRC_COUNT,
    parameter int unsigned DST_COUNT = BUS_DST_COUNT,
    parameter int          SETTLE    = 1
) (
    input  logic          clk_25mhz,
    input  logic          reset,
    bus_xfer_ctrl_if.slave bus
);

    localparam int unsigned DW = idx_w(DST_COUNT);
    localparam int unsigned CW = (SETTLE < 1) ? 1 : $clog2(SETTLE + 1);

    if (SETTLE < 1) begin : g_settle_chk
        $error("bus_xfer_ctrl: SETTLE must be >= 1");
    end

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [DW-1:0]        dst_q, dst_d;
    logic [SRC_COUNT-1:0] src_en_q, src_en_d;
    logic                 err_q, err_d;
    logic                 load_go_c;
    logic                 req_bad_c;
    logic [SRC_COUNT-1:0] src_onehot_c;

    assign req_bad_c    = (32'(bus.req_src) >= SRC_COUNT) || (32'(bus.req_dst) >= DST_COUNT);
    assign src_onehot_c = SRC_COUNT'(1) << bus.req_src;

    always_ff @(posedge clk_25mhz or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            dst_q    <= '0;
            src_en_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            dst_q    <= dst_d;
            src_en_q <= src_en_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        dst_d     = dst_q;
        src_en_d  = src_en_q;
        err_d     = err_q;
        load_go_c = 1'b0;
        case (state_q)
            IDLE: begin
                src_en_d = '0;
                err_d    = 1'b0;
                if (bus.req_valid) begin
                    dst_d = bus.req_dst;
                    // Out-of-range requests skip the bus entirely and just report.
                    if (req_bad_c) begin
                        err_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        src_en_d = src_onehot_c;
                        cnt_d    = CW'(SETTLE);
                        state_d  = DRIVE;
                    end
                end
            end
            DRIVE: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    load_go_c = 1'b1;
                    state_d   = LOAD;
                end
            end
            LOAD: begin
                src_en_d = '0;
                state_d  = DONE;
            end
            DONE: begin
                err_d   = 1'b0;
                state_d = IDLE;
            end
            default: begin
                src_en_d = '0;
                state_d  = IDLE;
            end
        endcase
    end

    assign bus.req_ready  = (state_q == IDLE);
    assign bus.busy       = (state_q != IDLE);
    assign bus.done       = (state_q == DONE);
    assign bus.err        = err_q;
    assign bus.src_enable = src_en_q;

    bus_sink_bank #(
        .WIDTH     (WIDTH),
        .DST_COUNT (DST_COUNT)
    ) u_sink (
        .clk_25mhz (clk_25mhz),
        .reset     (reset),
        .load_idx  (dst_q),
        .load_en   (load_go_c),
        .data      (bus.bus_in),
        .dst_load  (bus.dst_load),
        .dst_data  (bus.dst_data)
    );

endmodule

// File: tb/tb_bus_xfer_ctrl.sv
// Directed bench: three controller instances (default, 3 sources, SETTLE=4) with a small bus mux.
module tb_bus_xfer_ctrl;

    logic clk_25mhz = 1'b0;
    logic rst_a, rst_b, rst_c;
    int   total = 0;
    int   bad   = 0;

    always #5 clk_25mhz = ~clk_25mhz;

    bus_xfer_ctrl_if                  ia ();
    bus_xfer_ctrl_if #(.SRC_COUNT(3)) ib ();
    bus_xfer_ctrl_if                  ic ();

    bus_xfer_ctrl dut_a (.clk_25mhz(clk_25mhz), .reset(rst_a), .bus(ia));
    bus_xfer_ctrl #(.SRC_COUNT(3)) dut_b (.clk_25mhz(clk_25mhz), .reset(rst_b), .bus(ib));
    bus_xfer_ctrl #(.SETTLE(4)) dut_c (.clk_25mhz(clk_25mhz), .reset(rst_c), .bus(ic));

    // Bench bus mux: sources 0..3 = 99, 55, aa, 66
    assign ia.bus_in = (ia.src_enable[0] ? 8'h99 : 8'h00) | (ia.src_enable[1] ? 8'h55 : 8'h00) |
                       (ia.src_enable[2] ? 8'haa : 8'h00) | (ia.src_enable[3] ? 8'h66 : 8'h00);
    assign ib.bus_in = (ib.src_enable[0] ? 8'h99 : 8'h00) | (ib.src_enable[1] ? 8'h55 : 8'h00) |
                       (ib.src_enable[2] ? 8'haa : 8'h00);

    typedef struct {
        logic [1:0]  src;
        logic [1:0]  dst;
        logic [31:0] exp_data;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_25mhz);
        #1;
    endtask

    // One full transfer on instance A with cycle-by-cycle timing checks (SETTLE=1).
    task automatic xfer_a(input logic [1:0] src, input logic [1:0] dst, input logic [31:0] exp_data);
        logic [3:0] oh_s;
        logic [3:0] oh_d;
        oh_s = 4'b0001 << src;
        oh_d = 4'b0001 << dst;
        chk("a_ready_pre", 32'(ia.req_ready), 32'd1);
        ia.req_src   = src;
        ia.req_dst   = dst;
        ia.req_valid = 1'b1;
        tick();
        ia.req_valid = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            chk($sformatf("a_en_c%0d", c),    32'(ia.src_enable), (c <= 2) ? 32'(oh_s) : 32'd0);
            chk($sformatf("a_load_c%0d", c),  32'(ia.dst_load),   (c == 2) ? 32'(oh_d) : 32'd0);
            chk($sformatf("a_done_c%0d", c),  32'(ia.done),       32'(c == 3));
            chk($sformatf("a_ready_c%0d", c), 32'(ia.req_ready),  32'(c == 4));
            chk($sformatf("a_busy_c%0d", c),  32'(ia.busy),       32'(c <= 3));
            chk($sformatf("a_err_c%0d", c),   32'(ia.err),        32'd0);
            if (c == 3) chk("a_dst_data", ia.dst_data, exp_data);
            if (c < 4) tick();
        end
    endtask

    initial begin
        vec_t       vecs [5];
        logic [3:0] bb_en [8];
        logic [3:0] prev;
        int         viol;

        vecs[0] = '{2'd2, 2'd1, 32'h0000_aa00};
        vecs[1] = '{2'd0, 2'd3, 32'h9900_aa00};
        vecs[2] = '{2'd3, 2'd0, 32'h9900_aa66};
        vecs[3] = '{2'd1, 2'd1, 32'h9900_5566};
        vecs[4] = '{2'd0, 2'd2, 32'h9999_5566};

        ia.req_valid = 1'b0; ia.req_src = '0; ia.req_dst = '0;
        ib.req_valid = 1'b0; ib.req_src = '0; ib.req_dst = '0;
        ic.req_valid = 1'b0; ic.req_src = '0; ic.req_dst = '0; ic.bus_in = 8'h00;
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        tick();
        tick();
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
        tick();

        // Idle state after reset
        chk("rst_en",    32'(ia.src_enable), 32'd0);
        chk("rst_data",  ia.dst_data,        32'd0);
        chk("rst_ready", 32'(ia.req_ready),  32'd1);
        chk("rst_busy",  32'(ia.busy),       32'd0);
        chk("rst_done",  32'(ia.done),       32'd0);
        chk("rst_load",  32'(ia.dst_load),   32'd0);

        for (int i = 0; i < 5; i++) begin
            xfer_a(vecs[i].src, vecs[i].dst, vecs[i].exp_data);
        end

        // Back-to-back with req_valid held: src0->dst3 then src3->dst0
        rst_a = 1'b1;
        tick();
        rst_a = 1'b0;
        chk("bb_rst_data", ia.dst_data, 32'd0);
        bb_en = '{4'h1, 4'h1, 4'h0, 4'h0, 4'h8, 4'h8, 4'h0, 4'h0};
        ia.req_src = 2'd0; ia.req_dst = 2'd3; ia.req_valid = 1'b1;
        tick();
        ia.req_src = 2'd3; ia.req_dst = 2'd0;
        prev = 4'h0;
        viol = 0;
        for (int c = 1; c <= 8; c++) begin
            chk($sformatf("bb_en_c%0d", c), 32'(ia.src_enable), 32'(bb_en[c-1]));
            if (!$onehot0(ia.src_enable)) viol++;
            if (prev != 4'h0 && ia.src_enable != 4'h0 && prev != ia.src_enable) viol++;
            prev = ia.src_enable;
            if (c == 4) chk("bb_ready_c4", 32'(ia.req_ready), 32'd1);
            if (c == 5) ia.req_valid = 1'b0;
            if (c == 3 || c == 7) chk($sformatf("bb_done_c%0d", c), 32'(ia.done), 32'd1);
            if (c == 8) chk("bb_data", ia.dst_data, 32'h9900_0066);
            tick();
        end
        chk("bb_overlap", 32'(viol), 32'd0);

        // SRC_COUNT=3: preload dst2, then an out-of-range source
        ib.req_src = 2'd1; ib.req_dst = 2'd2; ib.req_valid = 1'b1;
        tick();
        ib.req_valid = 1'b0;
        tick();
        tick();
        chk("b_pre_data", ib.dst_data, 32'h0055_0000);
        tick();
        chk("b_ready", 32'(ib.req_ready), 32'd1);
        ib.req_src = 2'd3; ib.req_dst = 2'd0; ib.req_valid = 1'b1;
        tick();
        ib.req_valid = 1'b0;
        chk("b_err_done",  32'(ib.done),       32'd1);
        chk("b_err_err",   32'(ib.err),        32'd1);
        chk("b_err_ready", 32'(ib.req_ready),  32'd0);
        chk("b_err_en1",   32'(ib.src_enable), 32'd0);
        chk("b_err_load1", 32'(ib.dst_load),   32'd0);
        tick();
        chk("b_err_ready2", 32'(ib.req_ready), 32'd1);
        chk("b_err_done2",  32'(ib.done),      32'd0);
        chk("b_err_err2",   32'(ib.err),       32'd0);
        chk("b_err_en2",    32'(ib.src_enable), 32'd0);
        chk("b_err_load2",  32'(ib.dst_load),   32'd0);
        chk("b_err_data",   ib.dst_data,        32'h0055_0000);

        // SETTLE=4: bus_in only matters at the LOAD closing edge
        ic.bus_in = 8'h00;
        ic.req_src = 2'd0; ic.req_dst = 2'd1; ic.req_valid = 1'b1;
        tick();
        ic.req_valid = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            chk($sformatf("c_en_c%0d", c),   32'(ic.src_enable), 32'h1);
            chk($sformatf("c_load_c%0d", c), 32'(ic.dst_load),   32'h0);
            tick();
        end
        chk("c_en_c5",   32'(ic.src_enable), 32'h1);
        chk("c_load_c5", 32'(ic.dst_load),   32'h2);
        ic.bus_in = 8'h5a;
        tick();
        ic.bus_in = 8'h00;
        chk("c_done_c6", 32'(ic.done),       32'd1);
        chk("c_data_c6", ic.dst_data,        32'h0000_5a00);
        chk("c_en_c6",   32'(ic.src_enable), 32'd0);
        tick();
        chk("c_ready_c7", 32'(ic.req_ready), 32'd1);

        // SETTLE=4: reset asserted during DRIVE cycle 2
        ic.req_src = 2'd1; ic.req_dst = 2'd2; ic.req_valid = 1'b1;
        tick();
        ic.req_valid = 1'b0;
        chk("cr_en_c1", 32'(ic.src_enable), 32'h2);
        tick();
        chk("cr_busy_c2", 32'(ic.busy), 32'd1);
        #1 rst_c = 1'b1;
        #1;
        chk("cr_en_async",   32'(ic.src_enable), 32'd0);
        chk("cr_data_async", ic.dst_data,        32'd0);
        chk("cr_busy_async", 32'(ic.busy),       32'd0);
        tick();
        rst_c = 1'b0;
        chk("cr_ready", 32'(ic.req_ready), 32'd1);
        for (int c = 0; c < 6; c++) begin
            chk($sformatf("cr_load_%0d", c), 32'(ic.dst_load),   32'd0);
            chk($sformatf("cr_done_%0d", c), 32'(ic.done),       32'd0);
            chk($sformatf("cr_en_%0d", c),   32'(ic.src_enable), 32'd0);
            tick();
        end
        chk("cr_data_end", ic.dst_data, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
